// File: rtl/pipelined_mac.sv
// Pipelined multiplier / multiply-accumulate with valid pipeline and clock enable.
// The operand product is formed and resized at the input, then carried through STAGES-1 slots to p.
module pipelined_mac #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int OUT_WIDTH = 18,
  parameter int STAGES    = 1,
  parameter int SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [A_WIDTH-1:0]   a,
  input  logic [B_WIDTH-1:0]   b,
  input  logic                 acc_en,
  input  logic                 acc_clear,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] p
);

  localparam int EXT_W = A_WIDTH + B_WIDTH + 8;
  localparam bit C_SGN = (SIGNED != 0);

  // Both operands are widened past OUT_WIDTH, so the low OUT_WIDTH bits of the
  // wide product are already the truncated or sign/zero-extended result.
  function automatic logic [OUT_WIDTH-1:0] mul_resize(input logic [A_WIDTH-1:0] fa,
                                                      input logic [B_WIDTH-1:0] fb);
    logic signed [EXT_W-1:0] ea;
    logic signed [EXT_W-1:0] eb;
    ea = {{(EXT_W-A_WIDTH){fa[A_WIDTH-1] & C_SGN}}, fa};
    eb = {{(EXT_W-B_WIDTH){fb[B_WIDTH-1] & C_SGN}}, fb};
    return OUT_WIDTH'(ea * eb);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] wrap_add(input logic [OUT_WIDTH-1:0] acc,
                                                    input logic [OUT_WIDTH-1:0] prod);
    return acc + prod;
  endfunction

  logic [OUT_WIDTH-1:0] w_prod_p0;
  logic [OUT_WIDTH-1:0] w_prod_fin;
  logic                 w_vld_fin;
  logic                 w_acc_fin;
  logic                 w_clr_fin;
  logic [OUT_WIDTH-1:0] r_p;
  logic                 r_out_valid;

  assign w_prod_p0 = mul_resize(a, b);

  generate
    if (STAGES == 1) begin : g_direct
      assign w_prod_fin = w_prod_p0;
      assign w_vld_fin  = in_valid;
      assign w_acc_fin  = acc_en;
      assign w_clr_fin  = acc_clear;
    end else begin : g_pipe
      logic [OUT_WIDTH-1:0] r_prod_p [STAGES-1];
      logic [STAGES-2:0]    r_vld_p;
      logic [STAGES-2:0]    r_acc_p;
      logic [STAGES-2:0]    r_clr_p;

      // ---- intermediate slots: product and sideband advance together on ce ----
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < STAGES-1; k++) r_prod_p[k] <= '0;
          r_vld_p <= '0;
          r_acc_p <= '0;
          r_clr_p <= '0;
        end else if (ce) begin
          r_prod_p[0] <= w_prod_p0;
          r_vld_p[0]  <= in_valid;
          r_acc_p[0]  <= acc_en;
          r_clr_p[0]  <= acc_clear;
          for (int k = 1; k < STAGES-1; k++) begin
            r_prod_p[k] <= r_prod_p[k-1];
            r_vld_p[k]  <= r_vld_p[k-1];
            r_acc_p[k]  <= r_acc_p[k-1];
            r_clr_p[k]  <= r_clr_p[k-1];
          end
        end
      end

      assign w_prod_fin = r_prod_p[STAGES-2];
      assign w_vld_fin  = r_vld_p[STAGES-2];
      assign w_acc_fin  = r_acc_p[STAGES-2];
      assign w_clr_fin  = r_clr_p[STAGES-2];
    end
  endgenerate

  // ---- output slot: p is the last pipeline register and the accumulator ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p         <= '0;
      r_out_valid <= 1'b0;
    end else if (ce) begin
      r_out_valid <= w_vld_fin;
      if (w_vld_fin) begin
        if (w_acc_fin && !w_clr_fin) r_p <= wrap_add(r_p, w_prod_fin);
        else                         r_p <= w_prod_fin;
      end
    end
  end

  assign p         = r_p;
  assign out_valid = r_out_valid;

endmodule
